mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory port between two requesters: port 0 is the CPU control unit (instruction fetch and load/store), port 1 is the debug/loader.
- Sequences each access with the memory's mem_addr_ready/mem_data_ready handshake.
- Returns read data and a one-cycle ack to the winning requester.
- Flags a bus error if memory does not respond within TIMEOUT cycles.

Parameters:
- TIMEOUT, 16, WAIT-state cycles without mem_data_ready before the access is aborted with an error; must be at least 1.
- FIXED_PRIORITY, 0, 0 selects round-robin; 1 means port 0 always wins contention.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  port 0 requests an access; held until m0_ack.
- m0_write  in  1  1 = store, 0 = load.
- m0_size  in  4  size/sign code, forwarded unchanged to mem_size.
- m0_addr  in  32  byte address.
- m0_wdata  in  32  store data.
- m0_rdata  out  32  load data, valid while m0_ack is high.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  qualifies m0_ack; access timed out.
- m1_req, m1_write, m1_size, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: same as the port 0 signals, for port 1.
- mem_addr  out  32  latched address.
- mem_wdata  out  32  latched store data.
- mem_size  out  4  latched size code.
- mem_read  out  1  load in progress.
- mem_write  out  1  store in progress.
- mem_addr_ready  out  1  address and command are valid.
- mem_rdata  in  32  memory read data.
- mem_data_ready  in  1  memory has completed the access.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including mem_addr/mem_wdata/mem_size and both rdata ports.
  - Round-robin pointer is set to "port 0 next"; timeout counter is 0.
- All outputs are registered. No combinational path from any input to any output.
- States are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise choose a winner:
    - Only one req high: that port wins.
    - Both high with FIXED_PRIORITY=1: port 0 wins.
    - Both high with FIXED_PRIORITY=0: the pointer port wins, then the pointer flips to the other port.
  - Latch the winner's addr, wdata, size and write into the mem_* registers, record the grant, go to ISSUE.
- ISSUE (one cycle):
  - mem_addr_ready=1.
  - mem_read = !write and mem_write = write.
  - Timeout counter cleared. Go to WAIT.
- WAIT:
  - Hold mem_addr_ready, mem_read, mem_write and the latched fields steady.
  - On mem_data_ready=1:
    - Capture mem_rdata into the granted port's rdata (0 for stores).
    - Drop mem_addr_ready, mem_read and mem_write.
    - Go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT:
    - Drop the same three signals.
    - Set the granted port's rdata to 0 and arm err.
    - Go to RESP.
  - If mem_data_ready and the timeout occur in the same cycle, data wins and no error is raised.
- RESP (one cycle):
  - Granted port's ack=1; err=1 only if the access timed out.
  - The other port's ack/err stay 0.
  - Return to IDLE.
- rdata holds its value until that port's next completion.
- mem_data_ready outside WAIT is ignored.
- Latency: request seen in IDLE at cycle 0 gives ISSUE at 1 and WAIT at 2. With mem_data_ready in the first WAIT cycle, RESP/ack is at cycle 3. Throughput is at most one access per 4 cycles.
- Requesters must hold req and all request fields until ack, then drop req on the edge where ack is sampled.
  - A req that falls mid-transaction does not cancel it; ack is still issued.
  - Request fields are latched in IDLE, so later changes have no effect.
- The losing port's req stays pending and is granted in the next IDLE (ISSUE follows RESP after exactly one IDLE cycle).
- Reset asserted in any state aborts the access immediately. No ack is issued; memory outputs drop asynchronously.

Test Plan:
- Port 0 load, addr 0x100, size 4'b0000; memory returns 0xDEADBEEF with mem_data_ready in the first WAIT cycle -> mem_addr=0x100, mem_read=1 from cycle 1; m0_ack=1 and m0_rdata=0xDEADBEEF at cycle 3; m0_err=0; m1_ack stays 0.
- Port 1 store, addr 0x200, wdata 0x12345678, with mem_data_ready after 3 WAIT cycles -> mem_write=1 and mem_wdata=0x12345678 held for all 3 WAIT cycles; m1_ack pulses once at cycle 5 with m1_rdata=0.
- Both ports request continuously with FIXED_PRIORITY=0 and zero-wait memory -> grants alternate 0,1,0,1; acks at cycles 3, 7, 11, 15. Repeat with FIXED_PRIORITY=1 while m0 keeps re-requesting -> port 0 wins every contention.
- Memory never responds, TIMEOUT=16 -> exactly 16 WAIT cycles, then m0_ack=1, m0_err=1, m0_rdata=0; a following normal access completes with err=0.
- mem_data_ready rises in the same cycle the counter hits TIMEOUT -> ack with err=0 and the captured data.
- Reset asserted mid-WAIT, between clock edges -> mem_read/mem_addr_ready go to 0 before the next edge; no ack; after release, a fresh port 1 request is served normally, and port 0 has round-robin priority.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU control unit (port 0)
// and the debug/loader (port 1). Each access runs IDLE -> ISSUE -> WAIT -> RESP
// over the mem_addr_ready/mem_data_ready handshake. A WAIT that lasts TIMEOUT
// cycles is aborted with an error. Every output is driven straight from a flop.
module mem_arbiter #(
  parameter int unsigned TIMEOUT        = 16,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [3:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [3:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_size,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_addr_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_data_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_q;
  logic            gnt_q;       // port that owns the current access
  logic            rr_ptr_q;    // round-robin: port that wins the next tie
  logic [CW-1:0]   cnt_q;       // WAIT cycles seen without mem_data_ready
  logic [31:0]     m0_rdata_q, m1_rdata_q;
  logic            m0_ack_q, m1_ack_q, m0_err_q, m1_err_q;
  logic [31:0]     mem_addr_q, mem_wdata_q;
  logic [3:0]      mem_size_q;
  logic            mem_read_q, mem_write_q, mem_addr_ready_q;

  logic            win1;
  logic            contention;
  logic            sel_write;
  logic [3:0]      sel_size;
  logic [31:0]     sel_addr, sel_wdata;
  logic            timeout_hit;

  // Pick the winner among pending requests and mux its request fields.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned; an unassigned path would infer a latch.
    win1       = 1'b0;
    contention = m0_req && m1_req;
    if (m1_req && !m0_req)
      win1 = 1'b1;
    else if (contention && !FIXED_PRIORITY)
      win1 = rr_ptr_q;
    sel_write = win1 ? m1_write : m0_write;
    sel_size  = win1 ? m1_size  : m0_size;
    sel_addr  = win1 ? m1_addr  : m0_addr;
    sel_wdata = win1 ? m1_wdata : m0_wdata;
  end

  assign timeout_hit = (cnt_q + CW'(1)) == CW'(TIMEOUT);

  // Access sequencer; all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q          <= S_IDLE;
      gnt_q            <= 1'b0;
      rr_ptr_q         <= 1'b0;
      cnt_q            <= '0;
      m0_rdata_q       <= '0;
      m1_rdata_q       <= '0;
      m0_ack_q         <= 1'b0;
      m1_ack_q         <= 1'b0;
      m0_err_q         <= 1'b0;
      m1_err_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_size_q       <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_addr_ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            gnt_q            <= win1;
            mem_addr_q       <= sel_addr;
            mem_wdata_q      <= sel_wdata;
            mem_size_q       <= sel_size;
            mem_read_q       <= !sel_write;
            mem_write_q      <= sel_write;
            mem_addr_ready_q <= 1'b1;
            if (contention && !FIXED_PRIORITY)
              rr_ptr_q <= !win1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_data_ready || timeout_hit) begin
            // Data beats a simultaneous timeout; stores return zero.
            mem_addr_ready_q <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            if (gnt_q) begin
              m1_rdata_q <= (mem_data_ready && !mem_write_q) ? mem_rdata : '0;
              m1_ack_q   <= 1'b1;
              m1_err_q   <= !mem_data_ready;
            end else begin
              m0_rdata_q <= (mem_data_ready && !mem_write_q) ? mem_rdata : '0;
              m0_ack_q   <= 1'b1;
              m0_err_q   <= !mem_data_ready;
            end
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          m0_err_q <= 1'b0;
          m1_err_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m0_rdata       = m0_rdata_q;
  assign m0_ack         = m0_ack_q;
  assign m0_err         = m0_err_q;
  assign m1_rdata       = m1_rdata_q;
  assign m1_ack         = m1_ack_q;
  assign m1_err         = m1_err_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_size       = mem_size_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_addr_ready = mem_addr_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance (dut) and a
// fixed-priority instance (dut_fp) share all inputs. Cycle n is the state
// after rising edge n; outputs are sampled 1 time unit after that edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [3:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] mem_rdata;
  logic        mem_data_ready;

  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [3:0]  mem_size;
  logic        mem_read, mem_write, mem_addr_ready;

  logic [31:0] f_m0_rdata, f_m1_rdata, f_mem_addr, f_mem_wdata;
  logic        f_m0_ack, f_m0_err, f_m1_ack, f_m1_err;
  logic [3:0]  f_mem_size;
  logic        f_mem_read, f_mem_write, f_mem_addr_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(16), .FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_write(m1_write), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr_ready(mem_addr_ready),
    .mem_rdata(mem_rdata), .mem_data_ready(mem_data_ready)
  );

  mem_arbiter #(.TIMEOUT(16), .FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(f_m0_rdata), .m0_ack(f_m0_ack), .m0_err(f_m0_err),
    .m1_req(m1_req), .m1_write(m1_write), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(f_m1_rdata), .m1_ack(f_m1_ack), .m1_err(f_m1_err),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_size(f_mem_size),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr_ready(f_mem_addr_ready),
    .mem_rdata(mem_rdata), .mem_data_ready(mem_data_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m0_req = 0; m0_write = 0; m0_size = 4'hF; m0_addr = 32'hFFFF_FFFF; m0_wdata = 32'hFFFF_FFFF;
    m1_req = 0; m1_write = 0; m1_size = 4'hF; m1_addr = 32'hFFFF_FFFF; m1_wdata = 32'hFFFF_FFFF;
    mem_rdata = 32'hFFFF_FFFF; mem_data_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (m0_rdata !== 32'h0) begin bad++; $display("FAIL rst_m0_rdata got=%h exp=0", m0_rdata); end
    total++; if (m1_rdata !== 32'h0) begin bad++; $display("FAIL rst_m1_rdata got=%h exp=0", m1_rdata); end
    total++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin bad++; $display("FAIL rst_ack_err got=%b exp=0000", {m0_ack, m0_err, m1_ack, m1_err}); end
    total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_size !== 4'h0) begin bad++; $display("FAIL rst_mem_fields got=%h/%h/%h exp=0", mem_addr, mem_wdata, mem_size); end
    total++; if ({mem_read, mem_write, mem_addr_ready} !== 3'b0) begin bad++; $display("FAIL rst_mem_ctrl got=%b exp=000", {mem_read, mem_write, mem_addr_ready}); end
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_single_load();
    m0_write = 0; m0_size = 4'b0000; m0_addr = 32'h100; m0_wdata = 32'h0; m0_req = 1;
    tick(); // cycle 1
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL ld_issue_addr got=%h exp=100", mem_addr); end
    total++; if ({mem_read, mem_write, mem_addr_ready} !== 3'b101) begin bad++; $display("FAIL ld_issue_ctrl got=%b exp=101", {mem_read, mem_write, mem_addr_ready}); end
    total++; if (mem_size !== 4'b0000) begin bad++; $display("FAIL ld_issue_size got=%h exp=0", mem_size); end
    tick(); // cycle 2, first WAIT
    total++; if (mem_read !== 1'b1 || m0_ack !== 1'b0) begin bad++; $display("FAIL ld_wait got=%b%b exp=10", mem_read, m0_ack); end
    mem_rdata = 32'hDEAD_BEEF; mem_data_ready = 1;
    tick(); // cycle 3, RESP
    total++; if (m0_ack !== 1'b1 || m0_err !== 1'b0) begin bad++; $display("FAIL ld_ack got=%b%b exp=10", m0_ack, m0_err); end
    total++; if (m0_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ld_rdata got=%h exp=deadbeef", m0_rdata); end
    total++; if (m1_ack !== 1'b0) begin bad++; $display("FAIL ld_m1_ack got=%b exp=0", m1_ack); end
    total++; if ({mem_read, mem_addr_ready} !== 2'b00) begin bad++; $display("FAIL ld_resp_ctrl got=%b exp=00", {mem_read, mem_addr_ready}); end
    m0_req = 0; mem_data_ready = 0;
    tick(); // cycle 4, IDLE
    total++; if (m0_ack !== 1'b0) begin bad++; $display("FAIL ld_ack_pulse got=%b exp=0", m0_ack); end
  endtask

  task automatic test_wait_store();
    m1_write = 1; m1_size = 4'b0010; m1_addr = 32'h200; m1_wdata = 32'h1234_5678; m1_req = 1;
    tick(); // cycle 1
    total++; if (mem_addr !== 32'h200 || mem_size !== 4'b0010) begin bad++; $display("FAIL st_issue_addr got=%h/%h exp=200/2", mem_addr, mem_size); end
    total++; if ({mem_read, mem_write, mem_addr_ready} !== 3'b011) begin bad++; $display("FAIL st_issue_ctrl got=%b exp=011", {mem_read, mem_write, mem_addr_ready}); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      total++;
      if (mem_write !== 1'b1 || mem_addr_ready !== 1'b1 || mem_wdata !== 32'h1234_5678 || m1_ack !== 1'b0) begin
        bad++; $display("FAIL st_wait_c%0d got=wr%b rdy%b wd%h ack%b exp=wr1 rdy1 wd12345678 ack0", c, mem_write, mem_addr_ready, mem_wdata, m1_ack);
      end
      if (c == 4) begin mem_rdata = 32'hFFFF_0000; mem_data_ready = 1; end
    end
    tick(); // cycle 5
    total++; if (m1_ack !== 1'b1 || m1_err !== 1'b0) begin bad++; $display("FAIL st_ack got=%b%b exp=10", m1_ack, m1_err); end
    total++; if (m1_rdata !== 32'h0) begin bad++; $display("FAIL st_rdata got=%h exp=0", m1_rdata); end
    total++; if (m0_ack !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL st_m0_hold got=%b/%h exp=0/deadbeef", m0_ack, m0_rdata); end
    m1_req = 0; m1_write = 0; mem_data_ready = 0;
    tick(); // cycle 6
    total++; if (m1_ack !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL st_ack_pulse got=%b%b exp=00", m1_ack, mem_write); end
  endtask

  task automatic test_round_robin();
    logic e0, e1, f0;
    m0_write = 0; m0_addr = 32'h300; m1_write = 0; m1_addr = 32'h400;
    mem_rdata = 32'h0BAD_F00D; mem_data_ready = 1;
    m0_req = 1; m1_req = 1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      e0 = (c == 3) || (c == 11);
      e1 = (c == 7) || (c == 15);
      f0 = (c % 4) == 3;
      total++;
      if (m0_ack !== e0 || m1_ack !== e1) begin
        bad++; $display("FAIL rr_ack_c%0d got=%b%b exp=%b%b", c, m0_ack, m1_ack, e0, e1);
      end
      total++;
      if (f_m0_ack !== f0 || f_m1_ack !== 1'b0) begin
        bad++; $display("FAIL fp_ack_c%0d got=%b%b exp=%b0", c, f_m0_ack, f_m1_ack, f0);
      end
      if (c == 5 || c == 13) begin
        total++; if (mem_addr !== 32'h400) begin bad++; $display("FAIL rr_addr_c%0d got=%h exp=400", c, mem_addr); end
      end
      if (c == 7) begin
        total++; if (m1_rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL rr_m1_rdata got=%h exp=0badf00d", m1_rdata); end
      end
    end
    m0_req = 0; m1_req = 0; mem_data_ready = 0;
    tick();
  endtask

  task automatic test_timeout();
    mem_rdata = 32'hAAAA_5555; mem_data_ready = 0;
    m0_write = 0; m0_addr = 32'h500; m0_req = 1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      total++;
      if (m0_ack !== (c == 18)) begin bad++; $display("FAIL to_ack_c%0d got=%b exp=%b", c, m0_ack, (c == 18)); end
      if (c == 17) begin
        total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL to_read_last_wait got=%b exp=1", mem_read); end
      end
    end
    total++; if (m0_err !== 1'b1 || m0_rdata !== 32'h0) begin bad++; $display("FAIL to_err got=%b/%h exp=1/0", m0_err, m0_rdata); end
    total++; if (mem_read !== 1'b0 || mem_addr_ready !== 1'b0) begin bad++; $display("FAIL to_drop got=%b%b exp=00", mem_read, mem_addr_ready); end
    m0_req = 0;
    tick();
    total++; if (m0_err !== 1'b0) begin bad++; $display("FAIL to_err_pulse got=%b exp=0", m0_err); end
    m0_addr = 32'h504; m0_req = 1;
    tick();
    tick();
    mem_rdata = 32'h1122_3344; mem_data_ready = 1;
    tick();
    total++; if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'h1122_3344) begin bad++; $display("FAIL to_recover got=%b%b/%h exp=10/11223344", m0_ack, m0_err, m0_rdata); end
    m0_req = 0; mem_data_ready = 0;
    tick();
  endtask

  task automatic test_data_at_timeout();
    mem_rdata = 32'h5566_7788; mem_data_ready = 0;
    m0_write = 0; m0_addr = 32'h600; m0_req = 1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 17) begin
        total++; if (m0_ack !== 1'b0) begin bad++; $display("FAIL tie_early_ack got=%b exp=0", m0_ack); end
        mem_data_ready = 1;
      end
    end
    total++; if (m0_ack !== 1'b1 || m0_err !== 1'b0) begin bad++; $display("FAIL tie_ack got=%b%b exp=10", m0_ack, m0_err); end
    total++; if (m0_rdata !== 32'h5566_7788) begin bad++; $display("FAIL tie_rdata got=%h exp=55667788", m0_rdata); end
    m0_req = 0; mem_data_ready = 0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    mem_data_ready = 0;
    m0_write = 0; m0_addr = 32'h700; m1_write = 0; m1_addr = 32'h800;
    m0_req = 1; m1_req = 1;
    tick(); // cycle 1: port 0 wins, pointer moves to port 1
    total++; if (mem_addr !== 32'h700) begin bad++; $display("FAIL rw_first_grant got=%h exp=700", mem_addr); end
    tick();
    tick(); // cycle 3, still WAIT
    #3 reset = 1'b1;
    #1;
    total++; if ({mem_read, mem_addr_ready} !== 2'b00 || mem_addr !== 32'h0) begin bad++; $display("FAIL rw_async_drop got=%b%b/%h exp=00/0", mem_read, mem_addr_ready, mem_addr); end
    m0_req = 0; m1_req = 0;
    tick();
    tick();
    total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin bad++; $display("FAIL rw_no_ack got=%b%b exp=00", m0_ack, m1_ack); end
    #2 reset = 1'b0;
    m1_req = 1;
    tick();
    total++; if (mem_addr !== 32'h800 || mem_read !== 1'b1) begin bad++; $display("FAIL rw_m1_issue got=%h/%b exp=800/1", mem_addr, mem_read); end
    tick();
    mem_rdata = 32'hCAFE_0001; mem_data_ready = 1;
    tick();
    total++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || m1_rdata !== 32'hCAFE_0001) begin bad++; $display("FAIL rw_m1_ack got=%b%b/%h exp=10/cafe0001", m1_ack, m0_ack, m1_rdata); end
    m1_req = 0;
    tick();
    m0_req = 1; m1_req = 1;
    tick();
    total++; if (mem_addr !== 32'h700) begin bad++; $display("FAIL rw_ptr_reset got=%h exp=700", mem_addr); end
    tick();
    tick();
    total++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin bad++; $display("FAIL rw_m0_ack got=%b%b exp=10", m0_ack, m1_ack); end
    m0_req = 0; m1_req = 0; mem_data_ready = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_wait_store();
    test_round_robin();
    test_timeout();
    test_data_at_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
